// File: rtl/line_scan_sequencer.sv
// Line scan sequencer: walks the set bits of a captured mask in ascending order,
// holding each line for Dwell+1 cycles, and drives a 3-to-8 decoder's Enable/A/B/C.
module line_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Mode,
    input  logic [7:0]         Mask,
    input  logic [DWELL_W-1:0] Dwell,
    output logic               Enable,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               Done,
    output logic               dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [2:0]         idx, idx_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic               done_r, done_n;
    logic [7:0]         sh_mask, sh_mask_n;
    logic [DWELL_W-1:0] sh_dwell, sh_dwell_n;
    logic               sh_mode, sh_mode_n;
    logic [3:0]         nxt;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign nxt = next_above(sh_mask, idx);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            cnt      <= '0;
            done_r   <= 1'b0;
            sh_mask  <= 8'd0;
            sh_dwell <= '0;
            sh_mode  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            done_r   <= done_n;
            sh_mask  <= sh_mask_n;
            sh_dwell <= sh_dwell_n;
            sh_mode  <= sh_mode_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        done_n     = 1'b0;
        sh_mask_n  = sh_mask;
        sh_dwell_n = sh_dwell;
        sh_mode_n  = sh_mode;
        case (state)
            IDLE: begin
                if (Start && !Stop && (Mask != 8'd0)) begin
                    sh_mask_n  = Mask;
                    sh_dwell_n = Dwell;
                    sh_mode_n  = Mode;
                    state_n    = SCAN;
                    idx_n      = lowest_set(Mask);
                    cnt_n      = Dwell;
                end
            end
            SCAN: begin
                // Stop wins even on the last cycle of a sweep, suppressing Done.
                if (Stop) begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else if (nxt[3]) begin
                    idx_n = nxt[2:0];
                    cnt_n = sh_dwell;
                end else if (sh_mode) begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    idx_n  = lowest_set(sh_mask);
                    cnt_n  = sh_dwell;
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Enable    = (state == SCAN);
    assign A         = idx[2];
    assign B         = idx[1];
    assign C         = idx[0];
    assign Done      = done_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Directed bench for line_scan_sequencer: each cycle's {Enable, line, Done}
// is compared against hand-derived values.
module tb_line_scan_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Stop;
    logic       Mode;
    logic [7:0] Mask;
    logic [3:0] Dwell;
    logic       Enable;
    logic       A;
    logic       B;
    logic       C;
    logic       Done;
    logic       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    line_scan_sequencer #(.DWELL_W(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Stop      (Stop),
        .Mode      (Mode),
        .Mask      (Mask),
        .Dwell     (Dwell),
        .Enable    (Enable),
        .A         (A),
        .B         (B),
        .C         (C),
        .Done      (Done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // {Enable, A, B, C, Done} against expected
    task automatic expect_out(input string tag, input logic en, input logic [2:0] line,
                              input logic done);
        check(tag, {3'b000, Enable, A, B, C, Done}, {3'b000, en, line, done});
    endtask

    task automatic start_scan(input logic [7:0] m, input logic [3:0] d, input logic md);
        Mask  = m;
        Dwell = d;
        Mode  = md;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    logic [7:0] dec_f;
    assign dec_f = Enable ? (8'd1 << {A, B, C}) : 8'd0;

    // expected line per cycle for mask 00100101, dwell 1, single sweep
    logic [2:0] t2_line [0:5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5};

    initial begin
        Reset = 1'b1; Start = 1'b1; Stop = 1'b0; Mode = 1'b1;
        Mask = 8'h01; Dwell = 4'd0;

        // 1: reset held 2 cycles with Start high
        tick(); expect_out("rst_c1", 1'b0, 3'd0, 1'b0);
        check("rst_dbg", {7'd0, dbg_state}, 8'd0);
        tick(); expect_out("rst_c2", 1'b0, 3'd0, 1'b0);
        Reset = 1'b0;
        tick(); expect_out("rel_scan", 1'b1, 3'd0, 1'b0);
        Start = 1'b0;
        tick(); expect_out("rel_done", 1'b0, 3'd0, 1'b1);
        tick(); expect_out("rel_idle", 1'b0, 3'd0, 1'b0);

        // 2: single sweep over lines 0,2,5
        start_scan(8'b00100101, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("t2_c%0d", i + 1), 1'b1, t2_line[i], 1'b0);
            if (i == 4) check("t2_decf", dec_f, 8'b00100000);
            tick();
        end
        expect_out("t2_done", 1'b0, 3'd0, 1'b1);
        tick(); expect_out("t2_after", 1'b0, 3'd0, 1'b0);

        // 3: continuous alternation 0,7 with Dwell=0
        start_scan(8'b10000001, 4'd0, 1'b0);
        expect_out("t3_c1", 1'b1, 3'd0, 1'b0);
        tick(); expect_out("t3_c2", 1'b1, 3'd7, 1'b0);
        tick(); expect_out("t3_c3", 1'b1, 3'd0, 1'b1);
        tick(); expect_out("t3_c4", 1'b1, 3'd7, 1'b0);
        tick(); expect_out("t3_c5", 1'b1, 3'd0, 1'b1);
        Stop = 1'b1;
        tick(); expect_out("t3_stop", 1'b0, 3'd0, 1'b0);
        Stop = 1'b0;

        // 4: mid-scan Mask/Dwell/Mode changes and Start are ignored
        start_scan(8'b00000110, 4'd2, 1'b1);
        Mask = 8'hFF; Dwell = 4'd7; Mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("t4_c%0d", i + 1), 1'b1, (i < 3) ? 3'd1 : 3'd2, 1'b0);
            Start = (i == 1);
            tick();
        end
        Start = 1'b0;
        expect_out("t4_done", 1'b0, 3'd0, 1'b1);
        tick();

        // 5: Stop on second cycle of line 2, then restart
        start_scan(8'b00100101, 4'd1, 1'b1);
        tick(); tick(); tick();
        expect_out("t5_c4", 1'b1, 3'd2, 1'b0);
        Stop = 1'b1;
        tick(); expect_out("t5_stop", 1'b0, 3'd0, 1'b0);
        Stop = 1'b0;
        start_scan(8'b00100101, 4'd1, 1'b1);
        expect_out("t5_restart", 1'b1, 3'd0, 1'b0);
        // Stop on the final cycle of the sweep suppresses Done
        tick(); tick(); tick(); tick(); tick();
        expect_out("t5_c6", 1'b1, 3'd5, 1'b0);
        Stop = 1'b1;
        tick(); expect_out("t5_stop_end", 1'b0, 3'd0, 1'b0);
        // Start together with Stop in IDLE
        Start = 1'b1;
        tick(); expect_out("t5_both", 1'b0, 3'd0, 1'b0);
        Start = 1'b0; Stop = 1'b0;

        // 6: Start with empty mask
        Mask = 8'd0; Start = 1'b1;
        tick(); expect_out("t6_m0a", 1'b0, 3'd0, 1'b0);
        tick(); expect_out("t6_m0b", 1'b0, 3'd0, 1'b0);
        Start = 1'b0;
        // Reset during line 5
        start_scan(8'b00100101, 4'd1, 1'b1);
        tick(); tick(); tick(); tick();
        expect_out("t6_c5", 1'b1, 3'd5, 1'b0);
        Reset = 1'b1;
        tick(); expect_out("t6_reset", 1'b0, 3'd0, 1'b0);
        Reset = 1'b0;
        tick(); expect_out("t6_post", 1'b0, 3'd0, 1'b0);

        // single mask bit, Dwell=0, continuous: Done every cycle after the first
        start_scan(8'b00001000, 4'd0, 1'b0);
        expect_out("t7_c1", 1'b1, 3'd3, 1'b0);
        tick(); expect_out("t7_c2", 1'b1, 3'd3, 1'b1);
        tick(); expect_out("t7_c3", 1'b1, 3'd3, 1'b1);
        Stop = 1'b1;
        tick(); expect_out("t7_stop", 1'b0, 3'd0, 1'b0);
        Stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_scan_sequencer.md
Name: line_scan_sequencer

Overview:
Sequential front end for the 3-to-8 line decoder. It walks a programmable subset of the 8 decoder lines in ascending order, holding each selected line for a programmable dwell time. It drives the decoder's Enable, A, B and C inputs directly, so downstream F is one-hot on the active line and all-zero when idle. It supports single-sweep and continuous-scan modes and signals sweep completion with a Done pulse.

Parameters:
DWELL_W, 4, width of the Dwell input. Each line is held for Dwell+1 cycles.

Ports:
Clock  input  1  rising-edge clock; the only clock.
Reset  input  1  synchronous, active-high; overrides all other inputs.
Start  input  1  begins a sweep when idle; ignored while scanning.
Stop   input  1  aborts a scan; has priority over Start.
Mode   input  1  0 = continuous scan, 1 = single sweep.
Mask   input  8  Mask[i]=1 means line i is included in the scan.
Dwell  input  DWELL_W  hold time per line, minus 1.
Enable output 1  registered; high while scanning; goes to the decoder Enable.
A      output 1  registered line index bit 2 (MSB).
B      output 1  registered line index bit 1.
C      output 1  registered line index bit 0 (LSB).
Done   output 1  registered one-cycle pulse at the end of each complete sweep.

Behaviour:
- States: IDLE and SCAN. All outputs are registered.
- Reset (synchronous, any state): state=IDLE, Enable=0, {A,B,C}=000, Done=0, dwell counter=0, shadow Mask/Dwell/Mode=0.
- IDLE, Start=1, Stop=0, Mask!=0:
  - Capture Mask, Dwell and Mode into shadow registers.
  - On the next edge: state=SCAN, Enable=1, {A,B,C}=index of the lowest set bit of Mask, counter=Dwell.
- IDLE, Start=1 with Mask=0: ignored; stay in IDLE, no Done.
- SCAN, each cycle:
  - Counter>0: decrement; the line is held.
  - Counter==0: search for the next set shadow-Mask bit strictly above the current index.
    - Found: move to that line and reload counter=Dwell.
    - Not found, Mode=1: state=IDLE, Enable=0, {A,B,C}=000, Done=1 for one cycle.
    - Not found, Mode=0: wrap to the lowest set bit, reload the counter, and pulse Done=1 for one cycle while Enable stays 1. With a single mask bit set, the line never changes, the counter reloads, and Done pulses every Dwell+1 cycles.
- Every line is visible on {A,B,C} with Enable=1 for exactly Dwell+1 consecutive cycles. There are no gap cycles between lines.
- Mask, Dwell and Mode changes during SCAN have no effect until the next Start from IDLE.
- Start during SCAN: ignored.
- Stop during SCAN: on the next edge, state=IDLE, Enable=0, {A,B,C}=000, Done=0. This holds even if the same cycle was the end of a sweep.
- Stop and Start together in IDLE: stay in IDLE.
- Reset asserted mid-sweep: on the next edge all outputs are at their reset values. Start is honoured on the first cycle after Reset deasserts.
- Done is never asserted while Reset is high, and never asserted in two consecutive cycles unless Dwell=0 and exactly one mask bit is set in continuous mode.

Test Plan:
1. Reset held for 2 cycles with Start=1 -> Enable=0, {A,B,C}=000, Done=0 throughout; first edge after release enters SCAN.
2. Mask=8'b00100101, Dwell=1, Mode=1, Start pulsed at cycle 0 -> line 0 in cycles 1-2, line 2 in cycles 3-4, line 5 in cycles 5-6 (decoder F=8'b00100000). Cycle 7: Enable=0, {A,B,C}=000, Done=1. Cycle 8: Done=0.
3. Mask=8'b10000001, Dwell=0, Mode=0 -> lines alternate 0,7,0,7 each cycle; Done=1 on each cycle following line 7; Enable stays 1.
4. Mid-scan Mask change to 8'hFF and Dwell change to 7 while scanning Mask=8'b00000110, Dwell=2 -> sequence stays line 1 (3 cycles), then line 2 (3 cycles).
5. Stop asserted on the second cycle of line 2 in test 2 -> next edge Enable=0, {A,B,C}=000, no Done; a subsequent Start restarts at line 0.
6. Start with Mask=0 -> remains IDLE, Enable=0, Done never asserted. Reset asserted during line 5 -> immediate return to the reset state.
